// File: rtl/imul_arb_if.sv
// Requester, multiplier-issue and result-owner signals of imul_arb.
// slave = arbiter side, master = requesters / multiplier side.
interface imul_arb_if #(
    parameter int TAG_W = 9
);
    logic             req0_vld;
    logic [12:0]      req0_op;
    logic [64:0]      req0_R;
    logic [64:0]      req0_C;
    logic [TAG_W-1:0] req0_tag;
    logic             req0_rdy;
    logic             req1_vld;
    logic [12:0]      req1_op;
    logic [64:0]      req1_R;
    logic [64:0]      req1_C;
    logic [TAG_W-1:0] req1_tag;
    logic             req1_rdy;
    logic             mul_en;
    logic [12:0]      mul_op;
    logic [64:0]      mul_R;
    logic [64:0]      mul_C;
    logic             res_vld;
    logic [TAG_W-1:0] res_tag;
    logic             res_port;
    logic             busy;

    modport slave (
        input  req0_vld, req0_op, req0_R, req0_C, req0_tag,
        input  req1_vld, req1_op, req1_R, req1_C, req1_tag,
        output req0_rdy, req1_rdy,
        output mul_en, mul_op, mul_R, mul_C,
        output res_vld, res_tag, res_port, busy
    );

    modport master (
        output req0_vld, req0_op, req0_R, req0_C, req0_tag,
        output req1_vld, req1_op, req1_R, req1_C, req1_tag,
        input  req0_rdy, req1_rdy,
        input  mul_en, mul_op, mul_R, mul_C,
        input  res_vld, res_tag, res_port, busy
    );
endinterface

// File: rtl/imul_arb.sv
// Two-port arbiter for a LAT-cycle integer multiplier with result tagging.
// Define IMUL_ARB_FAIR_EN for round-robin; otherwise port 0 has fixed priority.
module imul_arb #(
    parameter int LAT   = 4,
    parameter int TAG_W = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkEn,
    input  logic       flush,
    imul_arb_if.slave  bus
);
    logic             prio;
    logic             ok;
    logic             pick1;
    logic             rdy0;
    logic             rdy1;
    logic             gnt;

    logic             mul_en_q,   mul_en_d;
    logic [12:0]      mul_op_q,   mul_op_d;
    logic [64:0]      mul_R_q,    mul_R_d;
    logic [64:0]      mul_C_q,    mul_C_d;
    logic [TAG_W-1:0] mul_tag_q,  mul_tag_d;
    logic             mul_port_q, mul_port_d;

    logic [LAT-1:0]             st_vld_q,  st_vld_d;
    logic [LAT-1:0][TAG_W-1:0]  st_tag_q,  st_tag_d;
    logic [LAT-1:0]             st_port_q, st_port_d;

`ifdef IMUL_ARB_FAIR_EN
    logic prio_q, prio_d;
    assign prio = prio_q;
`else
    assign prio = 1'b0;
`endif

    // Port 1 wins when it is the only requester or when it holds priority.
    assign ok    = clkEn & ~flush & ~rst;
    assign pick1 = bus.req1_vld & (~bus.req0_vld | prio);
    assign rdy1  = ok & pick1;
    assign rdy0  = ok & bus.req0_vld & ~pick1;
    assign gnt   = rdy0 | rdy1;

    always_comb begin
        mul_en_d   = mul_en_q;
        mul_op_d   = mul_op_q;
        mul_R_d    = mul_R_q;
        mul_C_d    = mul_C_q;
        mul_tag_d  = mul_tag_q;
        mul_port_d = mul_port_q;
        st_vld_d   = st_vld_q;
        st_tag_d   = st_tag_q;
        st_port_d  = st_port_q;
`ifdef IMUL_ARB_FAIR_EN
        prio_d     = prio_q;
`endif
        if (clkEn) begin
            mul_en_d = gnt;
            if (gnt) begin
                mul_op_d   = rdy1 ? bus.req1_op  : bus.req0_op;
                mul_R_d    = rdy1 ? bus.req1_R   : bus.req0_R;
                mul_C_d    = rdy1 ? bus.req1_C   : bus.req0_C;
                mul_tag_d  = rdy1 ? bus.req1_tag : bus.req0_tag;
                mul_port_d = rdy1;
`ifdef IMUL_ARB_FAIR_EN
                prio_d     = rdy0;
`endif
            end
            st_vld_d[0]  = mul_en_q;
            st_tag_d[0]  = mul_tag_q;
            st_port_d[0] = mul_port_q;
            for (int i = 1; i < LAT; i++) begin
                st_vld_d[i]  = st_vld_q[i-1];
                st_tag_d[i]  = st_tag_q[i-1];
                st_port_d[i] = st_port_q[i-1];
            end
            if (flush) begin
                st_vld_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_en_q   <= 1'b0;
            mul_op_q   <= '0;
            mul_R_q    <= '0;
            mul_C_q    <= '0;
            mul_tag_q  <= '0;
            mul_port_q <= 1'b0;
            st_vld_q   <= '0;
            st_tag_q   <= '0;
            st_port_q  <= '0;
`ifdef IMUL_ARB_FAIR_EN
            prio_q     <= 1'b0;
`endif
        end else begin
            mul_en_q   <= mul_en_d;
            mul_op_q   <= mul_op_d;
            mul_R_q    <= mul_R_d;
            mul_C_q    <= mul_C_d;
            mul_tag_q  <= mul_tag_d;
            mul_port_q <= mul_port_d;
            st_vld_q   <= st_vld_d;
            st_tag_q   <= st_tag_d;
            st_port_q  <= st_port_d;
`ifdef IMUL_ARB_FAIR_EN
            prio_q     <= prio_d;
`endif
        end
    end

    assign bus.req0_rdy = rdy0;
    assign bus.req1_rdy = rdy1;
    assign bus.mul_en   = mul_en_q;
    assign bus.mul_op   = mul_op_q;
    assign bus.mul_R    = mul_R_q;
    assign bus.mul_C    = mul_C_q;
    assign bus.res_vld  = st_vld_q[LAT-1];
    assign bus.res_tag  = st_tag_q[LAT-1];
    assign bus.res_port = st_port_q[LAT-1];
    assign bus.busy     = mul_en_q | (|st_vld_q);
endmodule

// File: tb/tb_imul_arb.sv
// Self-checking bench for imul_arb: directed scenarios plus random traffic
// against a queue model of issued operations keyed by clkEn-cycle count.
module tb_imul_arb;
    localparam int LAT   = 4;
    localparam int TAG_W = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clkEn = 1'b0;
    logic flush = 1'b0;

    imul_arb_if #(.TAG_W(TAG_W)) bus ();

    imul_arb #(.LAT(LAT), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .clkEn (clkEn),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic [TAG_W-1:0] tag;
        logic             port;
    } ent_t;

    ent_t        q[$];
    int          ecnt = 0;
    int          ncmp = 0;
    int          nerr = 0;
    bit          fair;
    bit          prio_m = 1'b0;
    logic [12:0] m_op = '0;
    logic [64:0] m_R = '0;
    logic [64:0] m_C = '0;
    bit          exp0, exp1;

    task automatic chk(input string nm, input logic [127:0] obs,
                       input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        prio_m = 1'b0;
        m_op = '0;
        m_R = '0;
        m_C = '0;
    endtask

    // Arbitration decision from the rules, then one clock, then output check.
    task automatic cycle();
        int     w;
        bit     mul_exp;
        #1;
        exp0 = 1'b0;
        exp1 = 1'b0;
        if (clkEn && !flush && !rst) begin
            if (bus.req0_vld && bus.req1_vld) begin
                w = (fair && prio_m) ? 1 : 0;
            end else if (bus.req0_vld) begin
                w = 0;
            end else if (bus.req1_vld) begin
                w = 1;
            end else begin
                w = -1;
            end
            exp0 = (w == 0);
            exp1 = (w == 1);
        end
        chk("req0_rdy", bus.req0_rdy, exp0);
        chk("req1_rdy", bus.req1_rdy, exp1);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (clkEn) begin
            ecnt++;
            if (flush) begin
                q.delete();
            end else if (exp0 || exp1) begin
                q.push_back('{due: ecnt + LAT,
                              tag: exp1 ? bus.req1_tag : bus.req0_tag,
                              port: exp1});
                m_op = exp1 ? bus.req1_op : bus.req0_op;
                m_R  = exp1 ? bus.req1_R  : bus.req0_R;
                m_C  = exp1 ? bus.req1_C  : bus.req0_C;
                if (fair) prio_m = exp0;
            end
        end
        @(negedge clk);
        while (q.size() > 0 && q[0].due < ecnt) void'(q.pop_front());
        mul_exp = 1'b0;
        foreach (q[i]) if (q[i].due == ecnt + LAT) mul_exp = 1'b1;
        chk("res_vld", bus.res_vld, q.size() > 0 && q[0].due == ecnt);
        if (q.size() > 0 && q[0].due == ecnt) begin
            chk("res_tag", bus.res_tag, q[0].tag);
            chk("res_port", bus.res_port, q[0].port);
        end
        chk("mul_en", bus.mul_en, mul_exp);
        chk("busy", bus.busy, q.size() > 0);
        chk("mul_op", bus.mul_op, m_op);
        chk("mul_R", bus.mul_R, m_R);
        chk("mul_C", bus.mul_C, m_C);
    endtask

    task automatic idle_req();
        bus.req0_vld = 1'b0;
        bus.req1_vld = 1'b0;
    endtask

    task automatic rnd_data();
        bus.req0_op  = 13'($urandom);
        bus.req0_R   = {1'($urandom), 32'($urandom), 32'($urandom)};
        bus.req0_C   = {1'($urandom), 32'($urandom), 32'($urandom)};
        bus.req0_tag = TAG_W'($urandom);
        bus.req1_op  = 13'($urandom);
        bus.req1_R   = {1'($urandom), 32'($urandom), 32'($urandom)};
        bus.req1_C   = {1'($urandom), 32'($urandom), 32'($urandom)};
        bus.req1_tag = TAG_W'($urandom);
    endtask

    task automatic async_reset_check();
        chk("rst_res_vld", bus.res_vld, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_mul_en", bus.mul_en, 1'b0);
        chk("rst_mul_op", bus.mul_op, 13'd0);
        chk("rst_mul_R", bus.mul_R, 65'd0);
        chk("rst_res_tag", bus.res_tag, 9'd0);
        chk("rst_res_port", bus.res_port, 1'b0);
        chk("rst_rdy0", bus.req0_rdy, 1'b0);
        chk("rst_rdy1", bus.req1_rdy, 1'b0);
    endtask

    initial begin
`ifdef IMUL_ARB_FAIR_EN
        fair = 1'b1;
`else
        fair = 1'b0;
`endif
        idle_req();
        rnd_data();
        bus.req0_vld = 1'b1;
        bus.req1_vld = 1'b1;

        // Reset state
        @(negedge clk);
        #1;
        async_reset_check();
        rst = 1'b0;
        clkEn = 1'b1;
        idle_req();
        cycle();

        // Single request, tag 0x05: mul_en next cycle, result LAT later
        bus.req0_vld = 1'b1;
        bus.req0_tag = 9'h005;
        cycle();
        chk("t032_mul_en", bus.mul_en, 1'b1);
        idle_req();
        repeat (4) cycle();
        chk("t032_res_vld", bus.res_vld, 1'b1);
        chk("t032_res_tag", bus.res_tag, 9'h005);
        chk("t032_res_port", bus.res_port, 1'b0);
        repeat (2) cycle();

        // Both ports request four cycles in a row
        for (int i = 0; i < 4; i++) begin
            rnd_data();
            bus.req0_vld = 1'b1;
            bus.req1_vld = 1'b1;
            cycle();
        end
        idle_req();
        repeat (6) cycle();

        // Stall of two cycles after issue stretches result timing
        bus.req1_vld = 1'b1;
        rnd_data();
        cycle();
        idle_req();
        cycle();
        clkEn = 1'b0;
        repeat (2) cycle();
        clkEn = 1'b1;
        repeat (6) cycle();

        // Three grants, then flush kills them all
        for (int i = 0; i < 3; i++) begin
            rnd_data();
            bus.req0_vld = 1'b1;
            cycle();
        end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("t035_busy", bus.busy, 1'b0);
        idle_req();
        repeat (5) cycle();

        // Flush while stalled is ignored
        bus.req0_vld = 1'b1;
        rnd_data();
        cycle();
        idle_req();
        clkEn = 1'b0;
        flush = 1'b1;
        repeat (2) cycle();
        clkEn = 1'b1;
        flush = 1'b0;
        repeat (6) cycle();

        // Asynchronous reset mid-operation
        bus.req0_vld = 1'b1;
        rnd_data();
        cycle();
        idle_req();
        cycle();
        rst = 1'b1;
        #1;
        async_reset_check();
        model_reset();
        cycle();
        rst = 1'b0;
        repeat (8) cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rnd_data();
            bus.req0_vld = ($urandom_range(0, 3) != 0);
            bus.req1_vld = ($urandom_range(0, 3) != 0);
            clkEn = ($urandom_range(0, 4) != 0);
            flush = ($urandom_range(0, 29) == 0);
            cycle();
        end
        clkEn = 1'b1;
        flush = 1'b0;
        idle_req();
        repeat (LAT + 3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
